// File: rtl/keypad_pkg.sv
// Key codes, debounce states and scan-frame result types shared by the keypad front end.
// Pure declarations; no timing or flow control.
package keypad_pkg;

    localparam logic [3:0]  KEY_STAR   = 4'hE;
    localparam logic [3:0]  KEY_HASH   = 4'hF;
    localparam logic [3:0]  KEY_CLR    = 4'hD;
    localparam logic [3:0]  BLANK      = 4'hA;
    localparam logic [15:0] BLANK_CODE = {4{BLANK}};

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS,
        DB_HELD,
        DB_RELEASE
    } db_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_kind_e;

    typedef struct packed {
        frame_kind_e kind;
        logic [3:0]  code;
    } frame_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                2'd2:    code = KEY_HASH;
                default: code = KEY_CLR;
            endcase
        end else if (col == 2'd3) begin
            code = 4'hA + {2'b00, row};
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Drives the one-cold keypad rows, synchronises COL and classifies each 4-row frame.
// Latency: frame result and frame_done strobe register on the last cycle of row 3.
// Backpressure: none; free-running, the consumer must act on every frame_done.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output frame_t     frame,
    output logic       frame_done
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [1:0]    row_idx;
    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [1:0]    hits;
    logic [3:0]    hit_code;
    logic [1:0]    row_hits;
    logic [3:0]    row_code;
    logic [2:0]    hit_sum;
    logic [1:0]    tot_hits;
    logic          slot_end;

    assign slot_end = (div_cnt == DIV_LAST);
    assign ROW      = ~(4'b0001 << row_idx);

    // Hit counts saturate at 2: anything beyond one key is simply MULTI.
    always_comb begin
        row_hits = 2'd0;
        row_code = hit_code;
        for (int c = 0; c < 4; c++) begin
            if (!col_s2[c]) begin
                if (row_hits != 2'd2) begin
                    row_hits = row_hits + 2'd1;
                end
                row_code = key_map(row_idx, 2'(c));
            end
        end
        hit_sum  = {1'b0, hits} + {1'b0, row_hits};
        tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            col_s1     <= 4'hF;
            col_s2     <= 4'hF;
            hits       <= 2'd0;
            hit_code   <= 4'h0;
            frame      <= '{kind: FR_NONE, code: 4'h0};
            frame_done <= 1'b0;
        end else begin
            col_s1     <= COL;
            col_s2     <= col_s1;
            frame_done <= 1'b0;
            if (slot_end) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                if (row_idx == 2'd3) begin
                    hits       <= 2'd0;
                    hit_code   <= 4'h0;
                    frame_done <= 1'b1;
                    frame.code <= row_code;
                    case (tot_hits)
                        2'd0:    frame.kind <= FR_NONE;
                        2'd1:    frame.kind <= FR_SINGLE;
                        default: frame.kind <= FR_MULTI;
                    endcase
                end else begin
                    hits     <= tot_hits;
                    hit_code <= row_code;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad front end: debounces scanned frames and maintains the 4-digit BCD password buffer.
// Latency: KEY_VALID/KEY/buffer update 1 cycle after the frame boundary completing debounce.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic        CLR,
    input  logic [3:0]  COL,
    output logic [3:0]  ROW,
    output logic [15:0] CODE,
    output logic [2:0]  DIGIT_CNT,
    output logic [3:0]  KEY,
    output logic        KEY_VALID,
    output logic        ENTER
);

    localparam int            CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);

    frame_t     frame;
    logic       frame_done;
    db_state_e  state;
    logic [CW-1:0] db_cnt;
    logic [3:0] hold_code;
    logic       same_single;
    logic       is_none;
    logic       accept;
    logic       take;
    logic       clr_pend;
    logic [1:0] wr_idx;
    logic [1:0] bs_idx;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .COL        (COL),
        .ROW        (ROW),
        .frame      (frame),
        .frame_done (frame_done)
    );

    assign same_single = (frame.kind == FR_SINGLE) && (frame.code == hold_code);
    assign is_none     = (frame.kind == FR_NONE);
    assign take        = accept && EN;
    assign wr_idx      = DIGIT_CNT[1:0];
    assign bs_idx      = 2'(DIGIT_CNT - 3'd1);

    always_comb begin
        accept = 1'b0;
        if (frame_done) begin
            case (state)
                DB_IDLE:  accept = (frame.kind == FR_SINGLE) && (DB_LAST == DB_ONE);
                DB_PRESS: accept = same_single && (db_cnt + DB_ONE == DB_LAST);
                default:  accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= DB_IDLE;
            db_cnt    <= '0;
            hold_code <= 4'h0;
        end else if (frame_done) begin
            case (state)
                DB_IDLE: begin
                    if (frame.kind == FR_SINGLE) begin
                        hold_code <= frame.code;
                        db_cnt    <= DB_ONE;
                        state     <= accept ? DB_HELD : DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (accept) begin
                        state <= DB_HELD;
                    end else if (same_single) begin
                        db_cnt <= db_cnt + DB_ONE;
                    end else begin
                        state <= DB_IDLE;
                    end
                end
                DB_HELD: begin
                    // The releasing NONE frame counts as the first of the release run.
                    if (is_none) begin
                        db_cnt <= DB_ONE;
                        state  <= (DB_LAST == DB_ONE) ? DB_IDLE : DB_RELEASE;
                    end
                end
                default: begin
                    if (!is_none) begin
                        state <= DB_HELD;
                    end else if (db_cnt + DB_ONE == DB_LAST) begin
                        state <= DB_IDLE;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CODE      <= BLANK_CODE;
            DIGIT_CNT <= 3'd0;
            KEY       <= 4'h0;
            KEY_VALID <= 1'b0;
            ENTER     <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            KEY_VALID <= 1'b0;
            ENTER     <= 1'b0;
            clr_pend  <= 1'b0;
            if (take) begin
                KEY       <= frame.code;
                KEY_VALID <= 1'b1;
            end
            if (CLR || clr_pend) begin
                CODE      <= BLANK_CODE;
                DIGIT_CNT <= 3'd0;
            end else if (take) begin
                if (frame.code <= 4'd9) begin
                    if (DIGIT_CNT < 3'd4) begin
                        CODE[{wr_idx, 2'b00} +: 4] <= frame.code;
                        DIGIT_CNT                  <= DIGIT_CNT + 3'd1;
                    end
                end else begin
                    case (frame.code)
                        KEY_STAR: begin
                            if (DIGIT_CNT != 3'd0) begin
                                CODE[{bs_idx, 2'b00} +: 4] <= BLANK;
                                DIGIT_CNT                  <= DIGIT_CNT - 3'd1;
                            end
                        end
                        KEY_CLR: begin
                            CODE      <= BLANK_CODE;
                            DIGIT_CNT <= 3'd0;
                        end
                        KEY_HASH: begin
                            // CODE stays valid alongside ENTER; the wipe lands next cycle.
                            if (DIGIT_CNT == 3'd4) begin
                                ENTER    <= 1'b1;
                                clr_pend <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboarded bench: frame-level keypad stimulus, run-length debounce reference model.
module tb_keypad_code_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        EN = 1'b1;
    logic        CLR = 1'b0;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [15:0] CODE;
    logic [2:0]  DIGIT_CNT;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic        ENTER;

    keypad_code_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .CLR       (CLR),
        .COL       (COL),
        .ROW       (ROW),
        .CODE      (CODE),
        .DIGIT_CNT (DIGIT_CNT),
        .KEY       (KEY),
        .KEY_VALID (KEY_VALID),
        .ENTER     (ENTER)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: bit r*4+c of pressed shorts row r to column c.
    logic [15:0] pressed = '0;
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!ROW[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) COL[c] = 1'b0;
    end

    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    typedef struct packed {
        logic [3:0]  key;
        logic [15:0] code;
        logic [2:0]  cnt;
        logic        enter;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  kv_count = 0;
    int  enter_count = 0;

    // Reference model state
    int         m_digits[$];
    bit         m_armed = 1'b1;
    int         m_run = 0;
    int         m_none = 0;
    logic [3:0] m_code = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_buf();
        logic [15:0] v = 16'hAAAA;
        foreach (m_digits[i]) v[i*4 +: 4] = 4'(m_digits[i]);
        return v;
    endfunction

    function automatic int idx_of(input logic [3:0] code);
        for (int i = 0; i < 16; i++) if (km[i] == code) return i;
        return 0;
    endfunction

    function automatic logic [15:0] kb(input logic [3:0] code);
        return 16'(1) << idx_of(code);
    endfunction

    task automatic model_accept(input logic [3:0] k, input bit clr);
        ev_t ev;
        if (clr) m_digits.delete();
        if (!EN) return;
        ev.key   = k;
        ev.enter = 1'b0;
        if (!clr) begin
            if (k <= 4'd9) begin
                if (m_digits.size() < 4) m_digits.push_back(int'(k));
            end else if (k == 4'hE) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (k == 4'hD) begin
                m_digits.delete();
            end else if (k == 4'hF && m_digits.size() == 4) begin
                ev.enter = 1'b1;
            end
        end
        ev.code = m_buf();
        ev.cnt  = 3'(m_digits.size());
        exp_q.push_back(ev);
        if (ev.enter) m_digits.delete();
    endtask

    // A key is taken after DEBOUNCE consecutive lone-key frames while armed;
    // it re-arms after DEBOUNCE consecutive empty frames.
    task automatic model_frame(input logic [15:0] mask, input bit clr);
        int n = $countones(mask);
        logic [3:0] code = 4'h0;
        for (int i = 0; i < 16; i++) if (mask[i]) code = km[i];
        if (m_armed) begin
            if (m_run > 0) begin
                if (n == 1 && code == m_code) m_run++;
                else m_run = 0;
            end else if (n == 1) begin
                m_run  = 1;
                m_code = code;
            end
            if (m_run == DEBOUNCE) begin
                model_accept(m_code, clr);
                m_armed = 1'b0;
                m_run   = 0;
                m_none  = 0;
            end else if (clr) begin
                m_digits.delete();
            end
        end else begin
            if (n == 0) begin
                m_none++;
                if (m_none == DEBOUNCE) m_armed = 1'b1;
            end else begin
                m_none = 0;
            end
            if (clr) m_digits.delete();
        end
    endtask

    task automatic next_frame();
        int guard = 0;
        do begin @(negedge CLK); guard++; end while (ROW != 4'b0111 && guard < 100);
        while (ROW != 4'b1110 && guard < 100) begin @(negedge CLK); guard++; end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL frame_sync: ROW=%b never rotated back to 1110", ROW);
        end
    endtask

    task automatic frame(input logic [15:0] mask, input bit clr);
        pressed = mask;
        next_frame();
        if (clr) CLR = 1'b1;
        model_frame(mask, clr);
        if (clr) begin
            @(negedge CLK);
            CLR = 1'b0;
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        for (int i = 0; i < hold; i++) frame(kb(code), 1'b0);
        for (int i = 0; i < rel; i++) frame(16'h0, 1'b0);
    endtask

    task automatic check_buf(input string name);
        check({name, "_code"}, 32'(CODE), 32'(m_buf()));
        check({name, "_cnt"}, 32'(DIGIT_CNT), 32'(m_digits.size()));
    endtask

    task automatic check_reset_outputs();
        check("rst_row", 32'(ROW), 32'h0000_000E);
        check("rst_code", 32'(CODE), 32'h0000_AAAA);
        check("rst_cnt", 32'(DIGIT_CNT), 32'd0);
        check("rst_key", 32'(KEY), 32'd0);
        check("rst_key_valid", 32'(KEY_VALID), 32'd0);
        check("rst_enter", 32'(ENTER), 32'd0);
    endtask

    // Monitor: pops one expected event per KEY_VALID strobe.
    ev_t ev_mon;
    bit  enter_d = 1'b0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            enter_d = 1'b0;
        end else begin
            if (enter_d) begin
                check("post_enter_code", 32'(CODE), 32'h0000_AAAA);
                check("post_enter_cnt", 32'(DIGIT_CNT), 32'd0);
            end
            enter_d = 1'b0;
            if (ENTER) enter_count++;
            if (KEY_VALID) begin
                kv_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: got KEY=%h, required no strobe", KEY);
                end else begin
                    ev_mon = exp_q.pop_front();
                    check("ev_key", 32'(KEY), 32'(ev_mon.key));
                    check("ev_code", 32'(CODE), 32'(ev_mon.code));
                    check("ev_cnt", 32'(DIGIT_CNT), 32'(ev_mon.cnt));
                    check("ev_enter", 32'(ENTER), 32'(ev_mon.enter));
                    enter_d = ev_mon.enter;
                end
            end else if (ENTER) begin
                check("enter_without_key_valid", 32'(ENTER), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv0, en0;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs();
        RST_N = 1'b1;

        // Entry and ENTER
        en0 = enter_count;
        press(4'h1, 3, 3); press(4'h2, 3, 3); press(4'h3, 3, 3); press(4'h4, 3, 3);
        check("entry_code", 32'(CODE), 32'h0000_4321);
        check("entry_cnt", 32'(DIGIT_CNT), 32'd4);
        press(4'hF, 3, 3);
        check("entry_enter_pulses", 32'(enter_count - en0), 32'd1);
        check_buf("after_enter");

        // Bounce rejection
        kv0 = kv_count;
        for (int i = 0; i < 2; i++) begin
            frame(kb(4'h5), 1'b0);
            frame(16'h0, 1'b0);
        end
        press(4'h5, 3, 3);
        check("bounce_kv", 32'(kv_count - kv0), 32'd1);
        check("bounce_nibble", 32'(CODE[3:0]), 32'd5);
        press(4'hD, 3, 3);

        // Multi-key and long hold
        kv0 = kv_count;
        for (int i = 0; i < 4; i++) frame(kb(4'h2) | kb(4'h8), 1'b0);
        for (int i = 0; i < 3; i++) frame(16'h0, 1'b0);
        check("multi_kv", 32'(kv_count - kv0), 32'd0);
        press(4'h7, 20, 3);
        check("hold_kv", 32'(kv_count - kv0), 32'd1);
        press(4'hD, 3, 3);

        // Backspace and short enter
        en0 = enter_count;
        press(4'h9, 3, 3); press(4'h0, 3, 3); press(4'hE, 3, 3);
        check("bksp_code", 32'(CODE), 32'h0000_AAA9);
        check("bksp_cnt", 32'(DIGIT_CNT), 32'd1);
        press(4'hF, 3, 3);
        check("short_enter", 32'(enter_count - en0), 32'd0);
        press(4'hE, 3, 3); press(4'hE, 3, 3);
        check_buf("bksp_empty");

        // Overflow then D
        press(4'h1, 3, 3); press(4'h2, 3, 3); press(4'h3, 3, 3); press(4'h4, 3, 3);
        press(4'h6, 3, 3);
        check("overflow_code", 32'(CODE), 32'h0000_4321);
        check("overflow_cnt", 32'(DIGIT_CNT), 32'd4);
        press(4'hD, 3, 3);
        check("dclear_code", 32'(CODE), 32'h0000_AAAA);

        // EN low discards keys
        kv0 = kv_count;
        EN = 1'b0;
        press(4'h3, 3, 3);
        check("en0_kv", 32'(kv_count - kv0), 32'd0);
        check_buf("en0_buf");
        EN = 1'b1;

        // CLR coincident with # acceptance
        en0 = enter_count;
        press(4'h1, 3, 3); press(4'h2, 3, 3); press(4'h3, 3, 3); press(4'h4, 3, 3);
        frame(kb(4'hF), 1'b0);
        frame(kb(4'hF), 1'b1);
        press(4'hF, 1, 3);
        check("clr_hash_enter", 32'(enter_count - en0), 32'd0);
        check("clr_hash_code", 32'(CODE), 32'h0000_AAAA);

        // Standalone CLR
        press(4'h8, 3, 3);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        m_digits.delete();
        @(negedge CLK);
        check_buf("clr_alone");

        // Reset mid-press; key still held afterwards is debounced afresh
        frame(kb(4'h3), 1'b0);
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        m_digits.delete();
        m_armed = 1'b1; m_run = 0; m_none = 0;
        @(negedge CLK);
        check_reset_outputs();
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        RST_N = 1'b1;
        kv0 = kv_count;
        press(4'h3, 3, 3);
        check("rst_reaccept_kv", 32'(kv_count - kv0), 32'd1);
        check("rst_reaccept_code", 32'(CODE), 32'h0000_AAA3);

        // Randomized key traffic
        for (int it = 0; it < 40; it++) begin
            logic [3:0] k;
            int mode;
            k    = km[$urandom_range(0, 15)];
            mode = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) EN = 1'b0;
            if (mode == 0) begin
                frame(kb(k), 1'b0);
                frame(16'h0, 1'b0);
                press(k, $urandom_range(1, 4), $urandom_range(3, 4));
            end else if (mode == 1) begin
                logic [15:0] m2;
                m2 = kb(k) | (16'(1) << $urandom_range(0, 15));
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) frame(m2, 1'b0);
                for (int i = 0; i < 3; i++) frame(16'h0, 1'b0);
            end else begin
                press(k, $urandom_range(1, 4), $urandom_range(3, 4));
            end
            EN = 1'b1;
        end
        repeat (3) frame(16'h0, 1'b0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_buf("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
